led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 98 +++++++++
 tb/tb_led_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: button-stepped LED pattern generator driven by a prescaled tick
module led_sequencer #(
  parameter int TICK_DIV        = 25000000,
  parameter int N_LEDS          = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              SYSCLK,
  input  logic              RST_N,
  input  logic              PANO_BUTTON,
  output logic [N_LEDS-1:0] LED,
  output logic [1:0]        MODE,
  output logic              TICK,
  output logic              PRESS
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {M_COUNT, M_WALK, M_BLINK, M_HOLD} mode_t;

  mode_t             r_mode;
  logic              r_sync1, r_sync2, r_db_level, r_db_prev, r_tick, r_press;
  logic [DW-1:0]     r_db_cnt;
  logic [PW-1:0]     r_presc;
  logic [N_LEDS-1:0] r_led;

  logic              w_press, w_tick;
  mode_t             w_next_mode;
  logic [N_LEDS-1:0] w_led_init, w_led_step;

  // A debounced rising edge wins over a tick landing in the same cycle
  assign w_press     = r_db_level & ~r_db_prev;
  assign w_tick      = (r_presc == P_LAST) & ~w_press;
  assign w_next_mode = mode_t'(r_mode + 2'd1);
  assign w_led_init  = (w_next_mode == M_WALK) ? N_LEDS'(1) :
                       (w_next_mode == M_HOLD) ? r_led : '0;
  assign w_led_step  = (r_mode == M_COUNT) ? r_led + N_LEDS'(1) :
                       (r_mode == M_WALK)  ? (r_led << 1) | (r_led >> (N_LEDS - 1)) :
                       (r_mode == M_BLINK) ? ~r_led : r_led;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= PANO_BUTTON;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: adopt the synchronised level once it has disagreed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == D_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  // Mode state machine, prescaler and registered pattern/strobe outputs
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode  <= M_COUNT;
      r_led   <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_press <= 1'b0;
    end else if (w_press) begin
      r_mode  <= w_next_mode;
      r_led   <= w_led_init;
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_press <= 1'b1;
    end else begin
      r_press <= 1'b0;
      r_tick  <= w_tick;
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) r_led <= w_led_step;
    end
  end

  assign LED   = r_led;
  assign MODE  = r_mode;
  assign TICK  = r_tick;
  assign PRESS = r_press;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: randomized self-checking bench against a behavioural sequencer model
module tb_led_sequencer;
  localparam int TD = 4;
  localparam int NL = 3;
  localparam int DC = 3;
  localparam int M  = 1 << NL;

  logic          SYSCLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          PANO_BUTTON = 1'b0;
  logic [NL-1:0] LED;
  logic [1:0]    MODE;
  logic          TICK, PRESS;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit raw_q[$];
  int m_level, m_run, m_pend, m_phase, m_mode, m_led, m_tick, m_press;

  led_sequencer #(.TICK_DIV(TD), .N_LEDS(NL), .DEBOUNCE_CYCLES(DC)) dut (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .PANO_BUTTON(PANO_BUTTON),
    .LED(LED), .MODE(MODE), .TICK(TICK), .PRESS(PRESS)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic model_reset();
    raw_q.delete();
    m_level = 0; m_run = 0; m_pend = 0; m_phase = 0;
    m_mode = 0; m_led = 0; m_tick = 0; m_press = 0;
  endtask

  // One clock edge of the sequencer as described by its rules, with b the raw button at that edge
  task automatic model_edge(input bit b);
    int s2, pr, tk;
    raw_q.push_back(b);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    s2 = (raw_q.size() == 3) ? int'(raw_q[0]) : 0;
    pr = m_pend;
    m_pend = 0;
    if (s2 != m_level) begin
      m_run++;
      if (m_run == DC) begin
        m_level = s2;
        m_run = 0;
        m_pend = s2;
      end
    end else m_run = 0;
    tk = (pr == 0 && m_phase == TD - 1) ? 1 : 0;
    m_phase = (pr != 0 || tk != 0) ? 0 : m_phase + 1;
    if (pr != 0) begin
      m_mode = (m_mode + 1) % 4;
      m_led = (m_mode == 1) ? 1 : (m_mode == 3) ? m_led : 0;
    end else if (tk != 0) begin
      m_led = (m_mode == 0) ? (m_led + 1) % M :
              (m_mode == 1) ? (m_led * 2) % M + m_led / (M / 2) :
              (m_mode == 2) ? M - 1 - m_led : m_led;
    end
    m_tick = tk;
    m_press = pr;
  endtask

  function automatic logic [NL+3:0] exp_v();
    return {m_led[NL-1:0], m_mode[1:0], m_tick[0], m_press[0]};
  endfunction

  // Advance one clock edge and the model; returns 1 time unit after the edge
  task automatic step();
    @(posedge SYSCLK);
    if (!RST_N) model_reset();
    else model_edge(PANO_BUTTON);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    PANO_BUTTON = 1'b0;
    repeat (2) step();
    checks++;
    if ({LED, MODE, TICK, PRESS} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got %b want %b", {LED, MODE, TICK, PRESS}, {(NL+4){1'b0}});
    end
    #3 RST_N = 1'b1;
  endtask

  task automatic test_count();
    int ticks = 0;
    int wrap = 0;
    int prev = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
        errors++;
        $display("FAIL count_cyc%0d: got %b want %b", i, {LED, MODE, TICK, PRESS}, exp_v());
      end
      if (TICK) begin
        ticks++;
        checks++;
        if (LED !== NL'(ticks % M)) begin
          errors++;
          $display("FAIL count_led_tick%0d: got %0d want %0d", ticks, LED, ticks % M);
        end
        if (prev == M - 1 && LED == 0) wrap = 1;
        prev = int'(LED);
      end
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL count_ticks: got %0d want 10", ticks);
    end
    checks++;
    if (wrap != 1) begin
      errors++;
      $display("FAIL count_wrap: got %0d want 1", wrap);
    end
  endtask

  task automatic test_press();
    int lat = -1;
    int np = 0;
    int pl = -1;
    int tl[$];
    for (int i = 1; i <= 20; i++) begin
      PANO_BUTTON = (i <= 10);
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
        errors++;
        $display("FAIL press_cyc%0d: got %b want %b", i, {LED, MODE, TICK, PRESS}, exp_v());
      end
      if (PRESS) begin
        np++;
        if (lat < 0) begin
          lat = i;
          pl = int'(LED);
        end
      end
      if (TICK && lat > 0) tl.push_back(int'(LED));
    end
    checks++;
    if (lat != 6) begin
      errors++;
      $display("FAIL press_latency: got %0d want 6", lat);
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL press_count: got %0d want 1", np);
    end
    checks++;
    if (MODE !== 2'd1) begin
      errors++;
      $display("FAIL press_mode: got %0d want 1", MODE);
    end
    checks++;
    if (pl != 1) begin
      errors++;
      $display("FAIL press_led_init: got %0d want 1", pl);
    end
    checks++;
    if (tl.size() < 3 || tl[0] != 2 || tl[1] != 4 || tl[2] != 1) begin
      errors++;
      $display("FAIL press_walk: got %p want 2,4,1", tl);
    end
  endtask

  task automatic test_glitch();
    int np = 0;
    logic [1:0] m0 = MODE;
    for (int g = 0; g < 5; g++) begin
      int hi = int'($urandom_range(1, 2));
      for (int i = 0; i < hi + 3; i++) begin
        PANO_BUTTON = (i < hi);
        step();
        checks++;
        if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
          errors++;
          $display("FAIL glitch_g%0d_cyc%0d: got %b want %b", g, i, {LED, MODE, TICK, PRESS}, exp_v());
        end
        if (PRESS) np++;
      end
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL glitch_press: got %0d want 0", np);
    end
    checks++;
    if (MODE !== m0) begin
      errors++;
      $display("FAIL glitch_mode: got %0d want %0d", MODE, m0);
    end
  endtask

  task automatic test_modes();
    int m0 = int'(MODE);
    for (int k = 1; k <= 4; k++) begin
      int want = (m0 + k) % 4;
      int ticks = 0;
      logic [NL-1:0] last;
      for (int i = 0; i < 16; i++) begin
        PANO_BUTTON = (i < 8);
        step();
        checks++;
        if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
          errors++;
          $display("FAIL modes_p%0d_cyc%0d: got %b want %b", k, i, {LED, MODE, TICK, PRESS}, exp_v());
        end
      end
      checks++;
      if (MODE !== 2'(want)) begin
        errors++;
        $display("FAIL modes_mode_p%0d: got %0d want %0d", k, MODE, want);
      end
      last = LED;
      for (int i = 0; i < 12; i++) begin
        step();
        checks++;
        if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
          errors++;
          $display("FAIL modes_run%0d_cyc%0d: got %b want %b", k, i, {LED, MODE, TICK, PRESS}, exp_v());
        end
        if (TICK) begin
          ticks++;
          if (want == 2) begin
            checks++;
            if (LED !== ~last) begin
              errors++;
              $display("FAIL modes_blink: got %b want %b", LED, ~last);
            end
            last = LED;
          end
        end
        if (want == 3) begin
          checks++;
          if (LED !== last) begin
            errors++;
            $display("FAIL modes_hold: got %b want %b", LED, last);
          end
        end
      end
      if (want == 3) begin
        checks++;
        if (ticks != 3) begin
          errors++;
          $display("FAIL modes_hold_ticks: got %0d want 3", ticks);
        end
      end
    end
  endtask

  task automatic test_press_on_tick();
    int n = 0;
    int nm;
    int led_before = 0;
    while (m_phase != 2 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (n >= 8) begin
      errors++;
      $display("FAIL align_phase: got %0d steps want <8", n);
    end
    nm = (int'(MODE) + 1) % 4;
    PANO_BUTTON = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) led_before = int'(LED);
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
        errors++;
        $display("FAIL align_cyc%0d: got %b want %b", i, {LED, MODE, TICK, PRESS}, exp_v());
      end
      if (i == 6) begin
        checks++;
        if ({TICK, PRESS} !== 2'b01) begin
          errors++;
          $display("FAIL align_strobes: got tick=%b press=%b want tick=0 press=1", TICK, PRESS);
        end
        checks++;
        if (LED !== NL'(nm == 1 ? 1 : nm == 3 ? led_before : 0)) begin
          errors++;
          $display("FAIL align_led_init: got %0d want mode %0d init", LED, nm);
        end
      end
      if (i > 6) begin
        checks++;
        if (TICK !== (i == 10)) begin
          errors++;
          $display("FAIL align_next_tick_cyc%0d: got %b want %b", i, TICK, i == 10);
        end
      end
    end
    PANO_BUTTON = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_async_reset();
    int np = 0;
    PANO_BUTTON = 1'b1;
    repeat (3) step();
    #($urandom_range(1, 7)) RST_N = 1'b0;
    #1;
    checks++;
    if ({LED, MODE, TICK, PRESS} !== '0) begin
      errors++;
      $display("FAIL arst_immediate: got %b want 0", {LED, MODE, TICK, PRESS});
    end
    PANO_BUTTON = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== '0) begin
        errors++;
        $display("FAIL arst_hold_cyc%0d: got %b want 0", i, {LED, MODE, TICK, PRESS});
      end
    end
    #3 RST_N = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
        errors++;
        $display("FAIL arst_after_cyc%0d: got %b want %b", i, {LED, MODE, TICK, PRESS}, exp_v());
      end
      if (PRESS) np++;
    end
    checks++;
    if (np != 0) begin
      errors++;
      $display("FAIL arst_press: got %0d want 0", np);
    end
  endtask

  task automatic test_held_through_reset();
    int lat = -1;
    RST_N = 1'b0;
    PANO_BUTTON = 1'b1;
    step();
    #3 RST_N = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
        errors++;
        $display("FAIL held_cyc%0d: got %b want %b", i, {LED, MODE, TICK, PRESS}, exp_v());
      end
      if (PRESS && lat < 0) lat = i;
    end
    checks++;
    if (lat != 2 + DC + 1) begin
      errors++;
      $display("FAIL held_latency: got %0d want %0d", lat, 2 + DC + 1);
    end
    PANO_BUTTON = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_random();
    int cyc = 0;
    while (cyc < 400) begin
      int len = int'($urandom_range(1, 9));
      PANO_BUTTON = ~PANO_BUTTON;
      for (int i = 0; i < len; i++) begin
        step();
        cyc++;
        checks++;
        if ({LED, MODE, TICK, PRESS} !== exp_v()) begin
          errors++;
          $display("FAIL random_cyc%0d: got %b want %b", cyc, {LED, MODE, TICK, PRESS}, exp_v());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_press();
    test_glitch();
    test_modes();
    test_press_on_tick();
    test_async_reset();
    test_held_through_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
